// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the CPU-to-memory bus bridge: the bridge FSM state
// encoding and the mask that turns a CPU byte address into a bus word address.
// No ports; imported by the bridge top and its testbench.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_bus_interface_if.sv
// mem_bus_interface_if
// Memory-side bus bundle between the bridge (master) and a memory responder
// (slave).
//   address     : word-aligned bus address        (master -> slave)
//   read/write  : one-hot bus strobes              (master -> slave)
//   writedata   : write data                       (master -> slave)
//   byteenable  : active byte lanes                (master -> slave)
//   waitrequest : responder not ready, hold strobe (slave -> master)
//   readdata    : read data, valid when not waiting (slave -> master)
interface mem_bus_interface_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest,
        output readdata
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter
// Counts consecutive cycles in which the responder holds waitrequest high.
//   clk      : clock
//   reset    : asynchronous active-high reset, clears the count
//   clear    : synchronous clear (used whenever the wait streak is broken)
//   count_en : this cycle is a waiting bus cycle
//   expired  : this waiting cycle is the WAIT_LIMIT-th in a row
module bus_timeout_counter #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] count;

    // Count waiting cycles; the streak restarts whenever clear is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

    // Expiry is flagged during the limit-th waiting cycle itself, so the
    // bridge leaves the bus at the edge that ends that cycle.
    always_comb begin
        expired = count_en && (count == LAST_WAIT);
    end

endmodule

// File: rtl/mem_bus_interface.sv
// mem_bus_interface
// Bridges a single-outstanding CPU request port onto a waitrequest-style
// memory bus, stalling the CPU until the bus transaction completes or
// times out.
//   clk, reset                    : clock, asynchronous active-high reset
//   req_valid/req_write/req_addr  : CPU request (held stable while stall=1)
//   req_wdata/req_byteenable      : CPU write data and byte lanes
//   stall                         : freezes CPU state update
//   rsp_valid/rsp_rdata/rsp_err   : one-cycle completion pulse, read data,
//                                   timeout flag
//   mem                           : bus master side (address, strobes,
//                                   writedata, byteenable, waitrequest,
//                                   readdata)
module mem_bus_interface #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [3:0]                 req_byteenable,
    output logic                       stall,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    mem_bus_interface_if.master        mem
);

    import bus_pkg::*;

    bus_state_t  state;
    bus_state_t  next_state;

    logic [31:0] address_q;
    logic [31:0] writedata_q;
    logic [3:0]  byteenable_q;
    logic        write_q;

    logic        accept;
    logic        skip;
    logic        expired;
    logic        tmo_clear;
    logic        tmo_count_en;

    // A request with no byte lanes never touches the bus.
    assign accept = (state == IDLE) && req_valid && (req_byteenable != 4'b0000);
    assign skip   = (state == IDLE) && req_valid && (req_byteenable == 4'b0000);

    assign tmo_count_en = (state == BUS) && mem.waitrequest;
    assign tmo_clear    = (state != BUS) || !mem.waitrequest;

    bus_timeout_counter #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmo_clear),
        .count_en (tmo_count_en),
        .expired  (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE always lasts exactly one cycle so a request
    // held through DONE is only taken once the bridge is back in IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = BUS;
                end else if (skip) begin
                    next_state = DONE;
                end
            end
            BUS: begin
                if (!mem.waitrequest || expired) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; stall is forced low during reset so the
    // CPU is not frozen by the bridge while everything is being reset.
    always_comb begin
        stall     = !reset && (((state == IDLE) && req_valid) || (state == BUS));
        rsp_valid = (state == DONE);
        mem.read  = (state == BUS) && !write_q;
        mem.write = (state == BUS) && write_q;
    end

    // Request capture; the copies stay put through BUS and afterwards, so
    // the bus fields keep their last values between transactions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            write_q      <= 1'b0;
        end else if (accept) begin
            address_q    <= word_align(req_addr);
            writedata_q  <= req_wdata;
            byteenable_q <= req_byteenable;
            write_q      <= req_write;
        end
    end

    assign mem.address    = address_q;
    assign mem.writedata  = writedata_q;
    assign mem.byteenable = byteenable_q;

    // Response capture; read data is kept across writes and skipped
    // requests, while a timeout zeroes it so stale data is never mistaken
    // for a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (skip) begin
            rsp_err <= 1'b0;
        end else if (state == BUS) begin
            if (!mem.waitrequest) begin
                rsp_err <= 1'b0;
                if (!write_q) begin
                    rsp_rdata <= mem.readdata;
                end
            end else if (expired) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb_mem_bus_interface
// Directed bench for mem_bus_interface built with WAIT_LIMIT=4. The bench
// plays both the CPU and the memory responder; expected values are written
// out by hand for each transaction.
module tb_mem_bus_interface;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byteenable;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    mem_bus_interface_if mem();

    mem_bus_interface #(
        .WAIT_LIMIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_byteenable (req_byteenable),
        .stall          (stall),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem            (mem)
    );

    int          checks = 0;
    int          errors = 0;

    int          stall_cycles;
    int          strobe_cycles;
    int          valid_pulses;
    int          valid_at;
    logic        type_ok;
    logic        bus_ok;
    logic        got_err;
    logic [31:0] got_rdata;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, plays a responder that holds waitrequest for
    // nwait strobe cycles, and records what happened over a fixed window.
    // Cycle 0 is the cycle the request is first presented.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input int nwait, input logic [31:0] rd,
                                 input logic [31:0] exp_addr);
        req_valid       = 1'b1;
        req_write       = wr;
        req_addr        = a;
        req_wdata       = d;
        req_byteenable  = be;
        mem.waitrequest = (nwait > 0);
        mem.readdata    = rd;
        stall_cycles    = 0;
        strobe_cycles   = 0;
        valid_pulses    = 0;
        valid_at        = -1;
        type_ok         = 1'b1;
        bus_ok          = 1'b1;
        got_err         = 1'b0;
        got_rdata       = 32'h0;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (stall) stall_cycles++;
            if (mem.read || mem.write) begin
                strobe_cycles++;
                if ((mem.read && mem.write) || (mem.write !== wr)) type_ok = 1'b0;
                if ((mem.address !== exp_addr) || (mem.writedata !== d) || (mem.byteenable !== be))
                    bus_ok = 1'b0;
                mem.waitrequest = (strobe_cycles <= nwait);
                req_addr        = ~a;
                req_wdata       = ~d;
                req_byteenable  = ~be;
                req_write       = ~wr;
            end
            if (rsp_valid) begin
                valid_pulses++;
                if (valid_at < 0) begin
                    valid_at  = i;
                    got_err   = rsp_err;
                    got_rdata = rsp_rdata;
                end
                req_valid = 1'b0;
            end
            step();
        end
        mem.waitrequest = 1'b0;
    endtask

    task automatic expectTxn(input string name, input int st, input int sb, input int va,
                             input logic err, input logic [31:0] rd);
        checkOutput({name, "_stall_cycles"},  stall_cycles,  st);
        checkOutput({name, "_strobe_cycles"}, strobe_cycles, sb);
        checkOutput({name, "_valid_at"},      valid_at,      va);
        checkOutput({name, "_valid_pulses"},  valid_pulses,  1);
        checkOutput({name, "_rsp_err"},       got_err,       err);
        checkOutput({name, "_rsp_rdata"},     got_rdata,     rd);
        checkOutput({name, "_strobe_type"},   type_ok,       1'b1);
        checkOutput({name, "_bus_fields"},    bus_ok,        1'b1);
    endtask

    int pulses;
    int first_valid;
    int second_rise;
    int rises;
    logic prev_strobe;
    logic stall_at_done;

    // Main directed sequence.
    initial begin
        reset           = 1'b0;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_addr        = 32'h0;
        req_wdata       = 32'h0;
        req_byteenable  = 4'h0;
        mem.waitrequest = 1'b0;
        mem.readdata    = 32'h0;

        #2 reset = 1'b1;
        req_valid = 1'b1;
        #1;
        checkOutput("rst_stall",      stall,          1'b0);
        checkOutput("rst_rsp_valid",  rsp_valid,      1'b0);
        checkOutput("rst_rsp_err",    rsp_err,        1'b0);
        checkOutput("rst_rsp_rdata",  rsp_rdata,      32'h0);
        checkOutput("rst_read",       mem.read,       1'b0);
        checkOutput("rst_write",      mem.write,      1'b0);
        checkOutput("rst_address",    mem.address,    32'h0);
        checkOutput("rst_writedata",  mem.writedata,  32'h0);
        checkOutput("rst_byteenable", mem.byteenable, 4'h0);
        req_valid = 1'b0;
        step();
        @(negedge clk);
        reset = 1'b0;
        step();

        // Zero-wait read.
        applyStimulus(1'b0, 32'hBFC00004, 32'h0, 4'hF, 0, 32'h8C220000, 32'hBFC00004);
        expectTxn("rd0", 2, 1, 2, 1'b0, 32'h8C220000);

        // Three-wait write to an unaligned address; read data must survive.
        applyStimulus(1'b1, 32'h00001003, 32'hDEADBEEF, 4'b1000, 3, 32'h0, 32'h00001000);
        expectTxn("wr3", 5, 4, 5, 1'b0, 32'h8C220000);
        checkOutput("wr3_addr_hold", mem.address,    32'h00001000);
        checkOutput("wr3_data_hold", mem.writedata,  32'hDEADBEEF);
        checkOutput("wr3_be_hold",   mem.byteenable, 4'b1000);

        // Responder never ready: abort after four waiting cycles.
        applyStimulus(1'b0, 32'h00002008, 32'h0, 4'hF, 100, 32'h12345678, 32'h00002008);
        expectTxn("tmo", 5, 4, 5, 1'b1, 32'h0);
        checkOutput("tmo_err_hold", rsp_err, 1'b1);

        // No byte lanes: no bus traffic, error cleared, data unchanged.
        applyStimulus(1'b1, 32'h00003000, 32'h11111111, 4'h0, 0, 32'h0, 32'h00002008);
        checkOutput("be0_stall_cycles",  stall_cycles,  1);
        checkOutput("be0_strobe_cycles", strobe_cycles, 0);
        checkOutput("be0_valid_at",      valid_at,      1);
        checkOutput("be0_valid_pulses",  valid_pulses,  1);
        checkOutput("be0_rsp_err",       got_err,       1'b0);
        checkOutput("be0_rsp_rdata",     got_rdata,     32'h0);
        checkOutput("be0_addr_hold",     mem.address,   32'h00002008);

        // One-wait read of a half-word lane pair.
        applyStimulus(1'b0, 32'h00000012, 32'h0, 4'h3, 1, 32'hCAFEF00D, 32'h00000010);
        expectTxn("rd1", 3, 2, 3, 1'b0, 32'hCAFEF00D);

        // Reset in the middle of a bus read.
        req_valid       = 1'b1;
        req_write       = 1'b0;
        req_addr        = 32'h00004000;
        req_wdata       = 32'h0;
        req_byteenable  = 4'hF;
        mem.waitrequest = 1'b1;
        step();
        checkOutput("mid_pre_read", mem.read, 1'b1);
        req_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        checkOutput("mid_read",      mem.read,    1'b0);
        checkOutput("mid_stall",     stall,       1'b0);
        checkOutput("mid_rsp_valid", rsp_valid,   1'b0);
        checkOutput("mid_address",   mem.address, 32'h0);
        pulses = 0;
        repeat (2) begin
            step();
            if (rsp_valid) pulses++;
        end
        @(negedge clk);
        reset = 1'b0;
        mem.waitrequest = 1'b0;
        repeat (3) begin
            step();
            if (rsp_valid) pulses++;
        end
        checkOutput("mid_no_pulse", pulses, 0);
        req_valid    = 1'b1;
        mem.readdata = 32'h55AA55AA;
        #1;
        checkOutput("mid_idle_stall", stall, 1'b1);
        step();
        checkOutput("mid_new_read", mem.read,    1'b1);
        checkOutput("mid_new_addr", mem.address, 32'h00004000);
        step();
        checkOutput("mid_new_valid", rsp_valid, 1'b1);
        checkOutput("mid_new_rdata", rsp_rdata, 32'h55AA55AA);
        req_valid = 1'b0;
        step();

        // Back-to-back: request held through DONE.
        req_valid       = 1'b1;
        req_write       = 1'b0;
        req_addr        = 32'h00000100;
        req_byteenable  = 4'hF;
        mem.waitrequest = 1'b0;
        mem.readdata    = 32'h0BADF00D;
        prev_strobe     = 1'b0;
        first_valid     = -1;
        second_rise     = -1;
        rises           = 0;
        stall_at_done   = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if ((mem.read || mem.write) && !prev_strobe) begin
                rises++;
                if (rises == 2 && second_rise < 0) second_rise = i;
            end
            prev_strobe = mem.read || mem.write;
            if (rsp_valid && first_valid < 0) begin
                first_valid   = i;
                stall_at_done = stall;
            end
            step();
        end
        req_valid = 1'b0;
        step();
        step();
        checkOutput("b2b_first_valid", first_valid, 2);
        checkOutput("b2b_gap",         second_rise - first_valid, 2);
        checkOutput("b2b_done_stall",  stall_at_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
